// File: rtl/lsu_issue_queue_pkg.sv
// Shared widths and payload types for the LSU issue queue and the load/store unit.
package lsu_issue_queue_pkg;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned TAG_W  = 6;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef struct packed {
        logic              rdy;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } lsq_operand_t;

    typedef struct packed {
        logic              valid;
        logic              is_ld;
        logic [TAG_W-1:0]  rob;
        lsq_operand_t      base;
        lsq_operand_t      sd;
        logic [DATA_W-1:0] offset;
    } lsq_entry_t;

    // Store data only matters for stores; loads need just the base.
    function automatic logic entry_ready(lsq_entry_t e);
        return e.valid && e.base.rdy && (e.is_ld || e.sd.rdy);
    endfunction

endpackage

// File: rtl/lsu_operand_capture.sv
// Operand wakeup: latches CDB data into a waiting operand whose producer tag matches.
module lsu_operand_capture
    import lsu_issue_queue_pkg::*;
(
    input  lsq_operand_t      op_i,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output lsq_operand_t      op_o
);

    always_comb begin
        op_o = op_i;
        if (!op_i.rdy && cdb_valid && (op_i.tag == cdb_tag)) begin
            op_o.rdy = 1'b1;
            op_o.val = cdb_data;
        end
    end

endmodule

// File: rtl/lsu_issue_queue.sv
// In-order memory-op issue queue: CDB wakeup, base+offset address formation,
// one issue per cycle onto the load/store unit with stall and flush handling.
module lsu_issue_queue
    import lsu_issue_queue_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic              disp_is_ld,
    input  logic [TAG_W-1:0]  disp_rob,
    input  logic              disp_base_rdy,
    input  logic [TAG_W-1:0]  disp_base_tag,
    input  logic [DATA_W-1:0] disp_base_val,
    input  logic              disp_sd_rdy,
    input  logic [TAG_W-1:0]  disp_sd_tag,
    input  logic [DATA_W-1:0] disp_sd_val,
    input  logic [DATA_W-1:0] disp_offset,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              load_stall,
    output logic              lsu_valid,
    output logic              lsu_is_ld,
    output logic [DATA_W-1:0] lsu_data,
    output logic [DATA_W-1:0] lsu_location,
    output logic [TAG_W-1:0]  lsu_rob
);

    lsq_entry_t        ent_q [DEPTH];
    lsq_entry_t        ent_d [DEPTH];
    lsq_operand_t      base_w [DEPTH];
    lsq_operand_t      sd_w [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              lsu_valid_q, lsu_valid_d, lsu_is_ld_q, lsu_is_ld_d;
    logic [DATA_W-1:0] lsu_data_q, lsu_data_d, lsu_location_q, lsu_location_d;
    logic [TAG_W-1:0]  lsu_rob_q, lsu_rob_d;

    lsq_operand_t      disp_base_in, disp_sd_in, disp_base_w, disp_sd_w;
    lsq_entry_t        head_e;
    logic              issue_c, disp_fire_c;

    assign disp_base_in = '{rdy: disp_base_rdy, tag: disp_base_tag, val: disp_base_val};
    assign disp_sd_in   = '{rdy: disp_sd_rdy, tag: disp_sd_tag, val: disp_sd_val};

    // Per-entry wakeup for both operands.
    for (genvar i = 0; i < DEPTH; i++) begin : g_wake
        lsu_operand_capture u_base (
            .op_i(ent_q[i].base), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
            .cdb_data(cdb_data), .op_o(base_w[i])
        );
        lsu_operand_capture u_sd (
            .op_i(ent_q[i].sd), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
            .cdb_data(cdb_data), .op_o(sd_w[i])
        );
    end

    // CDB-to-dispatch bypass so a same-cycle broadcast is not missed.
    lsu_operand_capture u_disp_base (
        .op_i(disp_base_in), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .op_o(disp_base_w)
    );
    lsu_operand_capture u_disp_sd (
        .op_i(disp_sd_in), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .op_o(disp_sd_w)
    );

    assign disp_ready  = (count_q < CNT_W'(DEPTH));
    assign head_e      = ent_q[head_q];
    assign issue_c     = entry_ready(head_e) && !load_stall && !flush;
    assign disp_fire_c = disp_valid && disp_ready && !flush;

    always_comb begin
        ent_d          = ent_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        lsu_valid_d    = 1'b0;
        lsu_is_ld_d    = lsu_is_ld_q;
        lsu_data_d     = lsu_data_q;
        lsu_location_d = lsu_location_q;
        lsu_rob_d      = lsu_rob_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid) begin
                ent_d[i].base = base_w[i];
                ent_d[i].sd   = sd_w[i];
            end
        end

        if (issue_c) begin
            lsu_valid_d         = 1'b1;
            lsu_is_ld_d         = head_e.is_ld;
            lsu_data_d          = head_e.is_ld ? '0 : head_e.sd.val;
            lsu_location_d      = head_e.base.val + head_e.offset;
            lsu_rob_d           = head_e.rob;
            ent_d[head_q].valid = 1'b0;
            head_d              = head_q + PTR_W'(1);
        end

        // Tail slot never aliases the issuing head: that needs count 0 or DEPTH.
        if (disp_fire_c) begin
            ent_d[tail_q] = '{valid: 1'b1, is_ld: disp_is_ld, rob: disp_rob,
                              base: disp_base_w, sd: disp_sd_w, offset: disp_offset};
            tail_d        = tail_q + PTR_W'(1);
        end

        case ({disp_fire_c, issue_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].valid = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            lsu_valid_q    <= 1'b0;
            lsu_is_ld_q    <= 1'b0;
            lsu_data_q     <= '0;
            lsu_location_q <= '0;
            lsu_rob_q      <= '0;
        end else begin
            ent_q          <= ent_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            lsu_valid_q    <= lsu_valid_d;
            lsu_is_ld_q    <= lsu_is_ld_d;
            lsu_data_q     <= lsu_data_d;
            lsu_location_q <= lsu_location_d;
            lsu_rob_q      <= lsu_rob_d;
        end
    end

    assign lsu_valid    = lsu_valid_q;
    assign lsu_is_ld    = lsu_is_ld_q;
    assign lsu_data     = lsu_data_q;
    assign lsu_location = lsu_location_q;
    assign lsu_rob      = lsu_rob_q;

endmodule
